// File: rtl/bit_reversed_pingpong_buffer_if.sv
// Bus bundle for bit_reversed_pingpong_buffer: LLR write stream, decoder control and PE read port.
// master = source/decoder side, slave = buffer.
interface bit_reversed_pingpong_buffer_if #(
  parameter int unsigned n    = 4,
  parameter int unsigned p    = 1,
  parameter int unsigned Q    = 6,
  parameter int unsigned W_IN = 4
);
  localparam int unsigned RA_W = (n > p + 2) ? n - p - 1 : 1;
  localparam int unsigned RD_W = (2 ** (p + 1)) * Q;

  logic              din_valid;
  logic [W_IN*Q-1:0] din;
  logic              din_ready;
  logic              frame_ready;
  logic              decoder_start;
  logic              decoder_done;
  logic              rd_en;
  logic [RA_W-1:0]   rd_addr;
  logic [RD_W-1:0]   dout;
  logic              dout_valid;
  logic [1:0]        frames_pending;
  logic              overflow_err;

  modport master (
    output din_valid, din, decoder_start, decoder_done, rd_en, rd_addr,
    input  din_ready, frame_ready, dout, dout_valid, frames_pending, overflow_err
  );

  modport slave (
    input  din_valid, din, decoder_start, decoder_done, rd_en, rd_addr,
    output din_ready, frame_ready, dout, dout_valid, frames_pending, overflow_err
  );
endinterface

// File: rtl/bit_reversed_pingpong_buffer.sv
// Two-bank channel LLR buffer: frames are written in bit-reversed order into one bank while the
// decoder reads the other. Optional macro NEG_ZERO_NORM_EN stores -0 lanes as +0.
module bit_reversed_pingpong_buffer #(
  parameter int unsigned n    = 4,
  parameter int unsigned p    = 1,
  parameter int unsigned Q    = 6,
  parameter int unsigned W_IN = 4
) (
  input logic                              clk,
  input logic                              rst_n,
  bit_reversed_pingpong_buffer_if.slave    bus
);
  localparam int unsigned N     = 2 ** n;
  localparam int unsigned BEATS = N / W_IN;
  localparam int unsigned WC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned R     = 2 ** (p + 1);

  typedef enum logic [1:0] {S_EMPTY, S_FILLING, S_FULL, S_DECODING} bank_state_e;

  bank_state_e       r_state [2];
  bank_state_e       w_state_nx [2];
  logic              r_wr_bank, w_wr_bank_nx;
  logic              r_rd_bank, w_rd_bank_nx;
  logic [WC_W-1:0]   r_wc, w_wc_nx;
  logic [1:0]        r_pending, w_pending_nx;
  logic              r_ovf;
  logic [Q-1:0]      r_mem [2][N];
  logic [R*Q-1:0]    w_rd_word;
  logic [R*Q-1:0]    r_dout;
  logic              r_dout_valid;
  logic              w_din_ready, w_accept, w_last, w_start, w_done;

  function automatic logic [n-1:0] bitrev(input logic [n-1:0] k);
    logic [n-1:0] r;
    for (int i = 0; i < int'(n); i++) r[i] = k[int'(n)-1-i];
    return r;
  endfunction

  function automatic logic [Q-1:0] norm_lane(input logic [Q-1:0] v);
`ifdef NEG_ZERO_NORM_EN
    if (v[Q-1] && (v[Q-2:0] == '0)) return '0;
`endif
    return v;
  endfunction

  assign w_din_ready = (r_state[r_wr_bank] == S_EMPTY) || (r_state[r_wr_bank] == S_FILLING);
  assign w_accept    = bus.din_valid && w_din_ready;
  assign w_last      = w_accept && (r_wc == WC_W'(BEATS - 1));
  assign w_done      = bus.decoder_done && (r_state[r_rd_bank] == S_DECODING);
  // done wins over a coincident start
  assign w_start     = bus.decoder_start && !bus.decoder_done && (r_state[r_rd_bank] == S_FULL);

  // Bank state machine and pointer next-state
  always_comb begin
    w_state_nx[0] = r_state[0];
    w_state_nx[1] = r_state[1];
    w_wr_bank_nx  = r_wr_bank;
    w_rd_bank_nx  = r_rd_bank;
    w_wc_nx       = r_wc;
    if (w_accept) begin
      if (w_last) begin
        w_state_nx[r_wr_bank] = S_FULL;
        w_wr_bank_nx          = ~r_wr_bank;
        w_wc_nx               = '0;
      end else begin
        w_state_nx[r_wr_bank] = S_FILLING;
        w_wc_nx               = r_wc + WC_W'(1);
      end
    end
    if (w_start) w_state_nx[r_rd_bank] = S_DECODING;
    if (w_done) begin
      w_state_nx[r_rd_bank] = S_EMPTY;
      w_rd_bank_nx          = ~r_rd_bank;
    end
    w_pending_nx = 2'((w_state_nx[0] == S_FULL) || (w_state_nx[0] == S_DECODING))
                 + 2'((w_state_nx[1] == S_FULL) || (w_state_nx[1] == S_DECODING));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state[0] <= S_EMPTY;
      r_state[1] <= S_EMPTY;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_wc       <= '0;
      r_pending  <= 2'd0;
      r_ovf      <= 1'b0;
    end else begin
      r_state[0] <= w_state_nx[0];
      r_state[1] <= w_state_nx[1];
      r_wr_bank  <= w_wr_bank_nx;
      r_rd_bank  <= w_rd_bank_nx;
      r_wc       <= w_wc_nx;
      r_pending  <= w_pending_nx;
      if (bus.din_valid && !w_din_ready) r_ovf <= 1'b1;
    end
  end

  // Storage is not reset; every lane of the beat lands at its bit-reversed position
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int j = 0; j < int'(W_IN); j++) begin
        r_mem[r_wr_bank][bitrev(n'(32'(r_wc) * W_IN + 32'(j)))] <= norm_lane(bus.din[j*Q +: Q]);
      end
    end
  end

  always_comb begin
    w_rd_word = '0;
    for (int j = 0; j < int'(R); j++) begin
      w_rd_word[j*Q +: Q] = r_mem[r_rd_bank][n'(32'(bus.rd_addr) * R + 32'(j))];
    end
  end

  // Read port: one-cycle latency, zeros outside DECODING, hold data when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else if (bus.rd_en) begin
      r_dout       <= (r_state[r_rd_bank] == S_DECODING) ? w_rd_word : '0;
      r_dout_valid <= 1'b1;
    end else begin
      r_dout_valid <= 1'b0;
    end
  end

  assign bus.din_ready      = w_din_ready;
  assign bus.frame_ready    = (r_state[r_rd_bank] == S_FULL);
  assign bus.dout           = r_dout;
  assign bus.dout_valid     = r_dout_valid;
  assign bus.frames_pending = r_pending;
  assign bus.overflow_err   = r_ovf;
endmodule

// File: tb/tb_bit_reversed_pingpong_buffer.sv
// Self-checking bench for bit_reversed_pingpong_buffer (defaults n=4, p=1, Q=6, W_IN=4) against a
// frame-queue reference model; honours NEG_ZERO_NORM_EN when defined.
module tb_bit_reversed_pingpong_buffer;
  localparam int unsigned QW  = 6;
  localparam int unsigned WIN = 4;
  localparam int unsigned NN  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bit_reversed_pingpong_buffer_if #(.n(4), .p(1), .Q(6), .W_IN(4)) bus_if ();

  bit_reversed_pingpong_buffer #(.n(4), .p(1), .Q(6), .W_IN(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  typedef struct {
    logic [1:0]  addr;
    logic [23:0] exp;
  } rd_vec_t;

  int n_checks = 0;
  int n_err    = 0;

  // Model: frames held in arrival order, front one belongs to the decoder
  logic [QW-1:0] m_frames [2][NN];
  logic [QW-1:0] m_part [NN];
  logic [QW-1:0] g_fr [NN];
  int            m_cnt;
  int            m_wc;
  bit            m_dec;
  bit            m_ovf;
  logic [23:0]   m_dout;
  bit            m_dv;

`ifdef NEG_ZERO_NORM_EN
  localparam logic [QW-1:0] EXP_NZ = 6'b000000;
`else
  localparam logic [QW-1:0] EXP_NZ = 6'b100000;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int brev4(input int x);
    int r = 0;
    for (int i = 0; i < 4; i++) if (((x >> i) & 1) != 0) r |= (1 << (3 - i));
    return r;
  endfunction

  function automatic logic [QW-1:0] model_norm(input logic [QW-1:0] v);
`ifdef NEG_ZERO_NORM_EN
    if (v == 6'b100000) return 6'b000000;
`endif
    return v;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_wc = 0; m_dec = 0; m_ovf = 0; m_dout = '0; m_dv = 0;
  endtask

  task automatic clear_inputs();
    bus_if.din_valid     = 1'b0;
    bus_if.din           = '0;
    bus_if.decoder_start = 1'b0;
    bus_if.decoder_done  = 1'b0;
    bus_if.rd_en         = 1'b0;
    bus_if.rd_addr       = '0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_din_ready"}, bus_if.din_ready, (m_cnt < 2));
    chk({tag, "_frame_ready"}, bus_if.frame_ready, (m_cnt > 0) && !m_dec);
    chk({tag, "_pending"}, bus_if.frames_pending, m_cnt);
    chk({tag, "_overflow"}, bus_if.overflow_err, m_ovf);
    chk({tag, "_dout_valid"}, bus_if.dout_valid, m_dv);
    chk({tag, "_dout"}, bus_if.dout, m_dout);
  endtask

  // Advance one clock: update the model from the applied inputs, then compare
  task automatic cycle();
    bit ready;
    logic [23:0] word;
    ready = (m_cnt < 2);
    word  = '0;
    for (int j = 0; j < 4; j++) word[j*QW +: QW] = m_frames[0][brev4(int'(bus_if.rd_addr) * 4 + j)];
    if (bus_if.rd_en) begin
      m_dv   = 1;
      m_dout = (m_cnt > 0 && m_dec) ? word : '0;
    end else begin
      m_dv = 0;
    end
    if (bus_if.decoder_done && m_cnt > 0 && m_dec) begin
      for (int k = 0; k < int'(NN); k++) m_frames[0][k] = m_frames[1][k];
      m_cnt--;
      m_dec = 0;
    end else if (bus_if.decoder_start && !bus_if.decoder_done && m_cnt > 0 && !m_dec) begin
      m_dec = 1;
    end
    if (bus_if.din_valid) begin
      if (ready) begin
        for (int j = 0; j < int'(WIN); j++)
          m_part[m_wc * WIN + j] = model_norm(bus_if.din[j*QW +: QW]);
        m_wc++;
        if (m_wc == 4) begin
          for (int k = 0; k < int'(NN); k++) m_frames[m_cnt][k] = m_part[k];
          m_cnt++;
          m_wc = 0;
        end
      end else begin
        m_ovf = 1;
      end
    end
    @(posedge clk);
    #1;
    check_outputs("cyc");
  endtask

  task automatic drive_beat(input int b);
    bus_if.din_valid = 1'b1;
    for (int j = 0; j < int'(WIN); j++) bus_if.din[j*QW +: QW] = g_fr[b * WIN + j];
  endtask

  task automatic load_beats(input int nb, input bit with_reads);
    for (int b = 0; b < nb; b++) begin
      drive_beat(b);
      if (with_reads) begin
        bus_if.rd_en   = 1'b1;
        bus_if.rd_addr = 2'($urandom_range(0, 3));
      end
      cycle();
    end
    clear_inputs();
  endtask

  task automatic pulse_start();
    clear_inputs(); bus_if.decoder_start = 1'b1; cycle(); clear_inputs();
  endtask

  task automatic pulse_done();
    clear_inputs(); bus_if.decoder_done = 1'b1; cycle(); clear_inputs();
  endtask

  task automatic read_all();
    for (int a = 0; a < 4; a++) begin
      bus_if.rd_en = 1'b1; bus_if.rd_addr = 2'(a); cycle();
    end
    clear_inputs();
  endtask

  task automatic rand_frame();
    for (int k = 0; k < int'(NN); k++)
      g_fr[k] = ($urandom_range(0, 7) == 0) ? 6'b100000 : 6'($urandom);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    clear_inputs();
    #1;
    model_reset();
    check_outputs(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  rd_vec_t tbl [4];

  initial begin
    tbl[0] = '{2'd0, {6'd12, 6'd4, 6'd8,  6'd0}};
    tbl[1] = '{2'd1, {6'd14, 6'd6, 6'd10, 6'd2}};
    tbl[2] = '{2'd2, {6'd13, 6'd5, 6'd9,  6'd1}};
    tbl[3] = '{2'd3, {6'd15, 6'd7, 6'd11, 6'd3}};
    for (int b = 0; b < 2; b++) for (int k = 0; k < int'(NN); k++) m_frames[b][k] = '0;

    clear_inputs();
    model_reset();
    @(negedge clk);
    do_reset("reset");

    // Bit-reversed ordering with natural LLR k = +k
    for (int k = 0; k < int'(NN); k++) g_fr[k] = 6'(k);
    load_beats(4, 0);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      bus_if.rd_en = 1'b1; bus_if.rd_addr = tbl[i].addr; cycle();
      chk("brev_dout", bus_if.dout, tbl[i].exp);
      chk("brev_valid", bus_if.dout_valid, 1'b1);
    end
    clear_inputs(); cycle();
    chk("hold_valid", bus_if.dout_valid, 1'b0);
    chk("hold_dout", bus_if.dout, tbl[3].exp);
    pulse_done();

    // Negative-zero lane handling
    for (int k = 0; k < int'(NN); k++) g_fr[k] = 6'd0;
    g_fr[0] = 6'b100000;
    load_beats(4, 0);
    pulse_start();
    bus_if.rd_en = 1'b1; bus_if.rd_addr = 2'd0; cycle(); clear_inputs();
    chk("negzero_lane", bus_if.dout[QW-1:0], EXP_NZ);
    pulse_done();

    // decoder_start with nothing ready is ignored, reads outside DECODING return zero
    pulse_start();
    chk("start_ignored_pending", bus_if.frames_pending, 2'd0);
    rand_frame(); load_beats(4, 0);
    chk("start_ignored_ready", bus_if.frame_ready, 1'b1);
    bus_if.rd_en = 1'b1; bus_if.rd_addr = 2'd1; cycle(); clear_inputs();
    chk("full_read_zero", bus_if.dout, 24'd0);
    pulse_start();

    // Ping-pong: load B while reading A
    rand_frame(); load_beats(4, 1);
    chk("pp_pending2", bus_if.frames_pending, 2'd2);
    pulse_done();
    chk("pp_ready_b", bus_if.frame_ready, 1'b1);
    chk("pp_pending1", bus_if.frames_pending, 2'd1);
    pulse_start();
    read_all();

    // Last beat of next frame coincides with decoder_done
    rand_frame(); load_beats(3, 0);
    drive_beat(3); bus_if.decoder_done = 1'b1; cycle(); clear_inputs();
    chk("coinc_pending", bus_if.frames_pending, 2'd1);
    chk("coinc_ready", bus_if.frame_ready, 1'b1);
    pulse_start();

    // Backpressure with both banks occupied
    rand_frame(); load_beats(4, 0);
    chk("bp_din_ready", bus_if.din_ready, 1'b0);
    rand_frame(); drive_beat(0); cycle(); clear_inputs();
    chk("bp_overflow", bus_if.overflow_err, 1'b1);
    read_all();
    pulse_done(); pulse_start(); read_all(); pulse_done();

    // Randomised traffic against the model
    do_reset("reset2");
    for (int c = 0; c < 800; c++) begin
      bus_if.din_valid     = ($urandom_range(0, 1) == 1);
      for (int j = 0; j < int'(WIN); j++)
        bus_if.din[j*QW +: QW] = ($urandom_range(0, 7) == 0) ? 6'b100000 : 6'($urandom);
      bus_if.decoder_start = ($urandom_range(0, 5) == 0);
      bus_if.decoder_done  = ($urandom_range(0, 9) == 0);
      bus_if.rd_en         = ($urandom_range(0, 1) == 1);
      bus_if.rd_addr       = 2'($urandom_range(0, 3));
      cycle();
    end
    clear_inputs();

    // Reset mid-frame, then a fresh frame must load from beat 0
    do_reset("reset3");
    rand_frame(); load_beats(2, 0);
    do_reset("reset_mid");
    for (int k = 0; k < int'(NN); k++) g_fr[k] = 6'(k);
    load_beats(4, 0);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      bus_if.rd_en = 1'b1; bus_if.rd_addr = tbl[i].addr; cycle();
      chk("post_reset_dout", bus_if.dout, tbl[i].exp);
    end
    clear_inputs(); cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/bit_reversed_pingpong_buffer.md
Name: bit_reversed_pingpong_buffer

Overview:
- Parametrised successor to the single-shot bit-reversed channel register. Sits between the channel LLR source and the SC decoder PE input mux.
- Accepts a frame of 2^n channel LLRs as W_IN LLRs per beat and stores them in bit-reversed order in one of two banks.
- Serves 2^(p+1)-LLR read words to the PEs from the other bank, so loading frame k+1 overlaps decoding of frame k.

Parameters:
- n, 4: code length N = 2^n.
- p, 1: log2 of PE count; read word = 2^(p+1) LLRs.
- Q, 6: LLR width, sign-magnitude, sign at MSB.
- W_IN, 4: LLRs per input beat; power of 2, 1 <= W_IN <= 2^n.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- din_valid  in  1  input beat valid.
- din  in  W_IN*Q  lane j = din[j*Q+:Q] = natural LLR index beat*W_IN+j.
- din_ready  out  1  write bank can accept a beat.
- frame_ready  out  1  read bank holds a complete frame not yet taken.
- decoder_start  in  1  pulse: decoder takes the ready frame.
- decoder_done  in  1  pulse: decoder finished the frame in the read bank.
- rd_en  in  1  read request.
- rd_addr  in  max(n-p-1,1)  read word address.
- dout  out  2^(p+1)*Q  lane j = stored position rd_addr*2^(p+1)+j.
- dout_valid  out  1  dout valid.
- frames_pending  out  2  count of banks that are FULL or DECODING (0..2).
- overflow_err  out  1  sticky: beat presented while din_ready = 0.

Behaviour:
- Bank state per bank: EMPTY -> FILLING (first accepted beat) -> FULL (beat 2^n/W_IN-1 accepted) -> DECODING (decoder_start while this bank is rd_bank and FULL) -> EMPTY (decoder_done).
- If W_IN = 2^n, EMPTY goes directly to FULL on the single beat.
- Pointers: wr_bank toggles when its bank becomes FULL; rd_bank toggles on decoder_done.
- Write addressing: beat counter wc in 0..2^n/W_IN-1. Natural LLR index k = wc*W_IN+j is stored at position bitrev_n(k). All W_IN lanes are written in the accepting cycle.
- Handshake: a beat is accepted when din_valid & din_ready. din_ready = (state[wr_bank] is EMPTY or FILLING), combinational from registered state.
- frame_ready = (state[rd_bank] == FULL), registered-state based.
- Read: rd_en sampled at clock edge k; dout and dout_valid are updated at edge k (visible in cycle k+1), so latency is 1 cycle. When rd_en = 0, dout holds and dout_valid = 0.
- Reads are legal only while state[rd_bank] == DECODING. A read in any other state returns all-zero dout with dout_valid = 1.
- Ignored events:
  - decoder_start when frame_ready = 0.
  - decoder_done when state[rd_bank] != DECODING.
  - A second decoder_start while DECODING.
- Simultaneous events:
  - Last write beat and decoder_done in the same cycle: both take effect.
  - When both banks become EMPTY/FULL in one cycle, frames_pending is computed from next-state values.
  - decoder_done and decoder_start in the same cycle: done applies to the current rd_bank, start is ignored.
- Overflow: din_valid & ~din_ready sets overflow_err; the data is dropped and the counter does not advance. Only reset clears overflow_err.
- Reset values: all banks EMPTY, wr_bank = rd_bank = 0, wc = 0, dout = 0, dout_valid = 0, frames_pending = 0, overflow_err = 0. Storage contents are don't-care.
- Reset mid-frame discards both banks; the next accepted beat is treated as beat 0.

Optional Feature:
- Macro: NEG_ZERO_NORM_EN.
- Defined: on write, any lane with sign = 1 and magnitude = 0 is stored as all-zero (+0), so the PEs never see -0.
- Undefined: lanes are stored bit-exact.

Test Plan:
- Bit-reversed ordering, defaults: load one frame with natural LLR k = +k over 4 beats, decoder_start, read rd_addr 0..3. Required: rd_addr 0 returns lanes {0,8,4,12}, rd_addr 3 returns {3,11,7,15}; dout_valid 1 cycle after each rd_en.
- Ping-pong overlap: load frame A, start, then load frame B while reading A.
  - frames_pending goes 1 -> 2.
  - After decoder_done, frame_ready = 1 for B and reads return B data.
- Backpressure: with both banks occupied, din_ready = 0. A beat presented then sets overflow_err = 1, is dropped, and frame data is unchanged.
- Corner cycles:
  - decoder_start with frame_ready = 0 has no effect.
  - decoder_done coincident with the last beat of the next frame gives frames_pending = 1 and frame_ready = 1 on the following cycle.
- Reset mid-frame: assert rst_n = 0 after 2 beats. Required: all outputs return to reset values, and a new 4-beat frame loads correctly from beat 0.
- NEG_ZERO_NORM_EN: write lane value 6'b100000. With the macro, it reads back 6'b000000; without it, 6'b100000.
